// File: rtl/perf_snapshot_unit.sv
// perf_snapshot_unit: periodically scans enabled perf counters into a valid/ready sample FIFO
module perf_snapshot_unit #(
  parameter int NrCounters    = 16,
  parameter int FifoDepth     = 8,
  parameter int IntervalWidth = 32,
  parameter int Xlen          = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic [IntervalWidth-1:0] interval_i,
  input  logic [NrCounters-1:0]    mask_i,
  output logic                     rd_req_o,
  output logic [4:0]               rd_addr_o,
  input  logic                     rd_gnt_i,
  input  logic [Xlen-1:0]          rd_data_i,
  output logic                     sample_valid_o,
  input  logic                     sample_ready_i,
  output logic [Xlen-1:0]          sample_data_o,
  output logic [4:0]               sample_idx_o,
  output logic                     sample_last_o,
  output logic                     busy_o,
  output logic [15:0]              missed_o
);
  localparam int Aw = $clog2(FifoDepth);
  localparam int Ew = Xlen + 6;
  typedef enum logic {IDLE, SCAN} state_e;
  state_e                   r_state, w_state_nxt;
  logic [IntervalWidth-1:0] r_timer;
  logic [NrCounters-1:0]    r_mask;
  logic [4:0]               r_idx, w_cur;
  logic [15:0]              r_missed;
  logic [Aw:0]              r_wr_ptr, r_rd_ptr;
  logic [Ew-1:0]            r_mem [FifoDepth];
  logic [Ew-1:0]            w_head;
  logic                     w_found, w_higher, w_tick, w_full, w_empty, w_pop, w_push, w_scan;
  assign w_tick   = en_i && (r_timer == interval_i);
  assign w_scan   = (r_state == SCAN);
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = ((r_wr_ptr ^ r_rd_ptr) == {1'b1, {Aw{1'b0}}});
  assign w_pop    = !w_empty && sample_ready_i;
  assign rd_req_o = w_scan && w_found && (!w_full || w_pop);
  assign rd_addr_o = (w_scan && w_found) ? w_cur : 5'd0;
  assign w_push   = rd_req_o && rd_gnt_i;
  assign busy_o   = w_scan;
  assign missed_o = r_missed;
  assign w_head   = r_mem[r_rd_ptr[Aw-1:0]];
  assign sample_valid_o = !w_empty;
  assign sample_data_o  = w_empty ? '0 : w_head[Ew-1:6];
  assign sample_idx_o   = w_empty ? '0 : w_head[5:1];
  assign sample_last_o  = !w_empty && w_head[0];
  // Lowest enabled index at or above the scan pointer, and whether any enabled index lies beyond it.
  always_comb begin
    w_cur = '0;
    w_found = 1'b0;
    w_higher = 1'b0;
    for (int i = NrCounters - 1; i >= 0; i--)
      if (r_mask[i] && 5'(i) >= r_idx) begin
        w_cur = 5'(i);
        w_found = 1'b1;
      end
    for (int i = 0; i < NrCounters; i++)
      if (r_mask[i] && 5'(i) > w_cur) w_higher = 1'b1;
  end
  // Scan starts on a tick from IDLE; it ends after the last push, or at once when nothing is enabled.
  always_comb begin
    w_state_nxt = r_state;
    if (!w_scan && w_tick) w_state_nxt = SCAN;
    else if (w_scan && (!w_found || (w_push && !w_higher))) w_state_nxt = IDLE;
  end
  // State register, interval timer, scan pointer with its latched mask, and saturating missed-tick count.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_idx    <= '0;
      r_mask   <= '0;
      r_missed <= '0;
    end else if (clr_i) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_idx    <= '0;
      r_mask   <= '0;
      r_missed <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= (!en_i || w_tick) ? '0 : r_timer + 1'b1;
      if (!w_scan && w_tick) begin
        r_idx  <= '0;
        r_mask <= mask_i;
      end else if (w_push) r_idx <= w_cur + 5'd1;
      if (w_scan && w_tick && r_missed != 16'hFFFF) r_missed <= r_missed + 16'd1;
    end
  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  // Sample storage needs no reset: outputs are masked while the FIFO is empty.
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr_ptr[Aw-1:0]] <= {rd_data_i, w_cur, !w_higher};
endmodule
